instruction_execute: RTL

Execute (EX) stage of the 5-stage MIPS pipeline, directly downstream of the instruction-decode stage. It consumes the ID/EX bundle (control bits, operands, sign-extended immediate, PC count, rt/rd), applies operand forwarding, decodes ALU control, computes the ALU result, branch target and zero flag, and registers everything into the EX/MEM pipeline register. Single clock; 1-cycle latency; stall and flush supported.

---
 rtl/mips_pkg.sv | 61 ++++++
 rtl/mips_alu.sv | 29 ++
 rtl/instruction_execute.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALUOp/funct encodings, ALU operations,
// forwarding selects and the control bundle carried into the MEM stage.
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } mem_ctrl_t;

    // Unknown funct codes and the reserved ALUOp fall back to ADD.
    function automatic alu_op_e alu_ctrl(
        input logic [1:0] aluop,
        input logic [5:0] funct
    );
        alu_op_e op;
        op = ALU_ADD;
        unique case (aluop)
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_RTYPE: begin
                unique case (funct)
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_NOR: op = ALU_NOR;
                    FUNCT_SLT: op = ALU_SLT;
                    default:   op = ALU_ADD;
                endcase
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational MIPS ALU; arithmetic wraps, SLT compares signed.
module mips_alu
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] result,
    output logic         zero
);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = a + b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/instruction_execute.sv
// EX stage: operand forwarding, ALU control, branch target and the
// EX/MEM pipeline register with stall/flush.
module instruction_execute
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        ALUOp,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              Branch,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] regA,
    input  logic [DATA_W-1:0] regB,
    input  logic [DATA_W-1:0] signExtend,
    input  logic [PC_W-1:0]   PcCount,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [1:0]        forwardA,
    input  logic [1:0]        forwardB,
    input  logic [DATA_W-1:0] fwdMemData,
    input  logic [DATA_W-1:0] fwdWbData,
    output logic [DATA_W-1:0] aluResult,
    output logic              zero,
    output logic [DATA_W-1:0] storeData,
    output logic [4:0]        writeReg,
    output logic [PC_W-1:0]   branchTarget,
    output logic              BranchOut,
    output logic              MemReadOut,
    output logic              MemWriteOut,
    output logic              MemToRegOut,
    output logic              RegWriteOut
);

    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opBf;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluRes;
    logic              aluZero;
    alu_op_e           aluOp;

    logic [DATA_W-1:0] aluResult_q, aluResult_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] storeData_q, storeData_d;
    logic [4:0]        writeReg_q, writeReg_d;
    logic [PC_W-1:0]   branchTarget_q, branchTarget_d;
    mem_ctrl_t         ctrl_q, ctrl_d;

    always_comb begin
        unique case (forwardA)
            FWD_MEM: opA = fwdMemData;
            FWD_WB:  opA = fwdWbData;
            default: opA = regA;
        endcase
        unique case (forwardB)
            FWD_MEM: opBf = fwdMemData;
            FWD_WB:  opBf = fwdWbData;
            default: opBf = regB;
        endcase
    end

    assign aluB  = ALUSrc ? signExtend : opBf;
    assign aluOp = alu_ctrl(ALUOp, signExtend[5:0]);

    mips_alu #(
        .W(DATA_W)
    ) u_alu (
        .a      (opA),
        .b      (aluB),
        .op     (aluOp),
        .result (aluRes),
        .zero   (aluZero)
    );

    // Flush takes priority over stall so a bubble always lands.
    always_comb begin
        aluResult_d    = aluResult_q;
        zero_d         = zero_q;
        storeData_d    = storeData_q;
        writeReg_d     = writeReg_q;
        branchTarget_d = branchTarget_q;
        ctrl_d         = ctrl_q;
        if (flush) begin
            aluResult_d    = '0;
            zero_d         = 1'b0;
            storeData_d    = '0;
            writeReg_d     = '0;
            branchTarget_d = '0;
            ctrl_d         = '0;
        end else if (!stall) begin
            aluResult_d    = aluRes;
            zero_d         = aluZero;
            storeData_d    = opBf;
            writeReg_d     = RegDst ? rd : rt;
            branchTarget_d = PcCount + signExtend[PC_W-1:0];
            ctrl_d         = '{branch:     Branch,
                               mem_read:   MemRead,
                               mem_write:  MemWrite,
                               mem_to_reg: MemToReg,
                               reg_write:  RegWrite};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aluResult_q    <= '0;
            zero_q         <= 1'b0;
            storeData_q    <= '0;
            writeReg_q     <= '0;
            branchTarget_q <= '0;
            ctrl_q         <= '0;
        end else begin
            aluResult_q    <= aluResult_d;
            zero_q         <= zero_d;
            storeData_q    <= storeData_d;
            writeReg_q     <= writeReg_d;
            branchTarget_q <= branchTarget_d;
            ctrl_q         <= ctrl_d;
        end
    end

    assign aluResult    = aluResult_q;
    assign zero         = zero_q;
    assign storeData    = storeData_q;
    assign writeReg     = writeReg_q;
    assign branchTarget = branchTarget_q;
    assign BranchOut    = ctrl_q.branch;
    assign MemReadOut   = ctrl_q.mem_read;
    assign MemWriteOut  = ctrl_q.mem_write;
    assign MemToRegOut  = ctrl_q.mem_to_reg;
    assign RegWriteOut  = ctrl_q.reg_write;

endmodule
